ssio_sdr_in_delay_cal: RTL and testbench
========================================

// Module: ssio_sdr_in_delay_cal
// PURPOSE
//  Input-delay training sequencer for the diff SDR source-synchronous receiver.
//  Sweeps a shared input-delay tap over all values while the far end sends an alternating pattern.
//  Records which taps sample cleanly and loads the centre of the widest passing window.
//  Sits in the output_clk domain beside the receiver; drives the delay-element tap/load controls.
// PARAMETERS
//  WIDTH          1      data lanes checked (matches receiver WIDTH)
//  TAP_WIDTH      5      delay tap bits; sweep covers 0..2^TAP_WIDTH-1
//  TRAIN_WORD     1'b1   WIDTH-bit training word; link sends TRAIN_WORD, ~TRAIN_WORD, ...
//  SETTLE_CYCLES  8      wait after each tap load before sampling (>=1)
//  SAMPLE_CYCLES  64     consecutive samples that must all pass per tap (>=2)
//  MIN_WINDOW     3      minimum passing window length for success (>=1)
//  DEFAULT_TAP    0      tap loaded on reset and after a failed calibration
// PORTS
//  clk            in   1          receiver output clock; all logic on rising edge
//  rst            in   1          asynchronous, active-high reset
//  start          in   1          pulse: begin calibration (ignored while busy)
//  data_in        in   WIDTH      receiver output_q
//  delay_tap      out  TAP_WIDTH  tap value to delay element
//  delay_load     out  1          1-cycle strobe: delay element captures delay_tap
//  busy           out  1          calibration in progress
//  done           out  1          1-cycle pulse at completion (success or fail)
//  error          out  1          sticky: last calibration found no window >= MIN_WINDOW
//  window_start   out  TAP_WIDTH  first tap of best window (last run)
//  window_len     out  TAP_WIDTH+1 length of best window; 0..2^TAP_WIDTH
// BEHAVIOUR
//  Reset: delay_tap=DEFAULT_TAP, delay_load=0, busy=0, done=0, error=0, window_start=0,
//   window_len=0; state IDLE. Reset mid-sweep aborts immediately; no done pulse.
//  FSM: IDLE -> LOAD -> SETTLE -> SAMPLE -> EVAL -> (LOAD next tap | CENTER) -> IDLE.
//  IDLE: start=1 -> tap=0, clear cur/best trackers, clear error, busy=1, go LOAD.
//  LOAD (1 cycle): delay_load=1 with delay_tap = sweep tap; go SETTLE.
//  SETTLE: count SETTLE_CYCLES cycles, data ignored; go SAMPLE.
//  SAMPLE: SAMPLE_CYCLES cycles. Sample k passes iff data_in is TRAIN_WORD or ~TRAIN_WORD
//   and (k=0 or data_in == ~previous sample). Any failing sample marks tap fail; sampling
//   still runs full length (fixed timing). Go EVAL.
//  EVAL (1 cycle): pass -> if cur_len==0 cur_start=tap; cur_len+=1; if new cur_len > best_len
//   (strict; lowest window wins ties) best_start=cur_start, best_len=new cur_len.
//   fail -> cur_len=0. tap==2^TAP_WIDTH-1 -> CENTER, else tap+=1 -> LOAD. No wrap: the
//   window never joins tap max to tap 0.
//  CENTER (1 cycle): window_start=best_start, window_len=best_len.
//   best_len>=MIN_WINDOW -> delay_tap=best_start+((best_len-1)>>1) (floor), error=0.
//   else delay_tap=DEFAULT_TAP, error=1. delay_load=1, done=1, busy=0 same cycle; go IDLE.
//  Per-tap time = 1+SETTLE_CYCLES+SAMPLE_CYCLES+1 cycles; total = 2^TAP_WIDTH*that + 1.
//  start asserted in the CENTER cycle or while busy is ignored. start in the cycle after
//   done starts a new run.
//  Arithmetic: counters sized for the parameter maxima; best_len/cur_len TAP_WIDTH+1 bits,
//   so an all-pass sweep reports 2^TAP_WIDTH without overflow.
//  delay_tap only changes on a delay_load cycle.
// TESTING
//  Defaults; model passes taps 10..20 only -> window_start=10, len=11, delay_tap=15, error=0, one done.
//  Passing taps 2..4 and 20..25 -> window_start=20, len=6, delay_tap=22 (floor of 22.5).
//  Equal windows 3..6 and 12..15 -> lowest wins: window_start=3, delay_tap=4.
//  No passing tap (or best len 2 < MIN_WINDOW) -> delay_tap=0, error=1, done pulses once.
//  All taps pass -> window_len=32, delay_tap=15; check total latency 32*74+1=2369 cycles, start->done.
//  rst mid-SAMPLE at tap 7 -> outputs at reset values immediately, no done; start again -> full sweep.
//  One glitch sample (non-alternating) in last sample cycle of tap 12 -> tap 12 fails, splitting the window.

Source files
------------

// File: rtl/ssio_sdr_in_delay_cal.sv
// ssio_sdr_in_delay_cal: input-delay training sequencer for the diff SDR source-synchronous receiver.
// Sweeps the delay tap 0..2^TAP_WIDTH-1 while the far end sends TRAIN_WORD/~TRAIN_WORD alternately,
// records which taps sample cleanly and loads the centre of the widest (lowest on ties) passing window.
// Ports:
//   clk, rst          receiver output clock; asynchronous active-high reset
//   start_i           pulse: begin calibration (ignored while busy or in the completion cycle)
//   data_in_i         receiver output word
//   delay_tap_o       tap value presented to the delay element
//   delay_load_o      1-cycle strobe: delay element captures delay_tap_o
//   busy_o            calibration in progress
//   done_o            1-cycle pulse at completion (success or failure)
//   error_o           sticky: last calibration found no window >= MIN_WINDOW
//   window_start_o    first tap of the best window of the last run
//   window_len_o      length of that window, 0..2^TAP_WIDTH
module ssio_sdr_in_delay_cal #(
    parameter int WIDTH = 1,
    parameter int TAP_WIDTH = 5,
    parameter logic [WIDTH-1:0] TRAIN_WORD = WIDTH'(1),
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 64,
    parameter int MIN_WINDOW = 3,
    parameter int DEFAULT_TAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     data_in_i,
    output logic [TAP_WIDTH-1:0] delay_tap_o,
    output logic                 delay_load_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [TAP_WIDTH-1:0] window_start_o,
    output logic [TAP_WIDTH:0]   window_len_o
);
    localparam int LW = TAP_WIDTH + 1;
    localparam int CMAX = SETTLE_CYCLES > SAMPLE_CYCLES ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_WIDTH-1:0] TAP_MAX = '1;
    localparam logic [TAP_WIDTH-1:0] TAP_DEF = TAP_WIDTH'(DEFAULT_TAP);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, EVAL, CENTER} state_t;

    state_t               state_q;
    logic [TAP_WIDTH-1:0] tap_q, cur_start_q, best_start_q;
    logic [LW-1:0]        cur_len_q, best_len_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     prev_q;
    logic                 pass_q;

    logic                 sample_ok, take, win_ok;
    logic [LW-1:0]        run_len, best_len_d, len_m1;
    logic [TAP_WIDTH-1:0] run_start, best_start_d, centre;

    // best_*_d is the tracker state after this tap's evaluation, so the
    // final tap's result can be published in the same cycle it is judged
    always_comb begin
        sample_ok    = (data_in_i == TRAIN_WORD || data_in_i == ~TRAIN_WORD) &&
                       (cnt_q == '0 || data_in_i == ~prev_q);
        run_len      = pass_q ? cur_len_q + LW'(1) : '0;
        run_start    = cur_len_q == '0 ? tap_q : cur_start_q;
        take         = pass_q && run_len > best_len_q;
        best_len_d   = take ? run_len : best_len_q;
        best_start_d = take ? run_start : best_start_q;
        win_ok       = best_len_d >= LW'(MIN_WINDOW);
        len_m1       = best_len_d - LW'(1);
        centre       = best_start_d + TAP_WIDTH'(len_m1 >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tap_q          <= '0;
            cur_start_q    <= '0;
            best_start_q   <= '0;
            cur_len_q      <= '0;
            best_len_q     <= '0;
            cnt_q          <= '0;
            prev_q         <= '0;
            pass_q         <= 1'b0;
            delay_tap_o    <= TAP_DEF;
            delay_load_o   <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            window_start_o <= '0;
            window_len_o   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    tap_q        <= '0;
                    cur_start_q  <= '0;
                    best_start_q <= '0;
                    cur_len_q    <= '0;
                    best_len_q   <= '0;
                    error_o      <= 1'b0;
                    busy_o       <= 1'b1;
                    delay_tap_o  <= '0;
                    delay_load_o <= 1'b1;
                    state_q      <= LOAD;
                end
                LOAD: begin
                    delay_load_o <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= SETTLE;
                end
                SETTLE: begin
                    cnt_q   <= cnt_q == SETTLE_LAST ? '0 : cnt_q + CW'(1);
                    state_q <= cnt_q == SETTLE_LAST ? SAMPLE : SETTLE;
                end
                // sampling always runs its full length so per-tap timing is fixed
                SAMPLE: begin
                    pass_q  <= sample_ok && (cnt_q == '0 || pass_q);
                    prev_q  <= data_in_i;
                    cnt_q   <= cnt_q + CW'(1);
                    state_q <= cnt_q == SAMPLE_LAST ? EVAL : SAMPLE;
                end
                EVAL: begin
                    cur_len_q    <= run_len;
                    cur_start_q  <= run_start;
                    best_len_q   <= best_len_d;
                    best_start_q <= best_start_d;
                    delay_load_o <= 1'b1;
                    if (tap_q == TAP_MAX) begin
                        window_start_o <= best_start_d;
                        window_len_o   <= best_len_d;
                        delay_tap_o    <= win_ok ? centre : TAP_DEF;
                        error_o        <= !win_ok;
                        done_o         <= 1'b1;
                        busy_o         <= 1'b0;
                        state_q        <= CENTER;
                    end else begin
                        tap_q       <= tap_q + TAP_WIDTH'(1);
                        delay_tap_o <= tap_q + TAP_WIDTH'(1);
                        state_q     <= LOAD;
                    end
                end
                CENTER: begin
                    done_o       <= 1'b0;
                    delay_load_o <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ssio_sdr_in_delay_cal.sv
// tb_ssio_sdr_in_delay_cal: randomized self-checking bench for the delay calibration sequencer.
module tb_ssio_sdr_in_delay_cal;
    localparam int NT = 32;
    localparam int LAT = NT * 74 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       data_in = 1'b0;
    logic [4:0] delay_tap;
    logic       delay_load, busy, done, error;
    logic [4:0] window_start;
    logic [5:0] window_len;

    int checks = 0;
    int errors = 0;

    logic [31:0] mask = '0;
    int          glitch = -1;
    int          cur_tap = 0;
    int          phase = 0;
    logic        tog = 1'b0;

    ssio_sdr_in_delay_cal dut (
        .clk(clk), .rst(rst), .start_i(start), .data_in_i(data_in),
        .delay_tap_o(delay_tap), .delay_load_o(delay_load), .busy_o(busy), .done_o(done),
        .error_o(error), .window_start_o(window_start), .window_len_o(window_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Delay-element/link model: a passing tap sees a clean alternating stream,
    // a failing tap sees random bits; the glitch tap repeats one word in its last sample cycle.
    initial forever begin
        @(posedge clk);
        #1;
        if (delay_load) begin
            cur_tap = int'(delay_tap);
            phase = 0;
        end else phase++;
        if (mask[cur_tap]) begin
            if (!(cur_tap == glitch && phase == 72)) tog = ~tog;
            data_in = tog;
        end else data_in = 1'($urandom);
    end

    // Longest run of passing taps, lowest start on ties, by exhaustive search over all spans.
    task automatic model(input logic [31:0] m, output int ws, output int wl, output int tap, output int err);
        logic [63:0] span;
        ws = 0;
        wl = 0;
        for (int s = 0; s < NT; s++)
            for (int e = s; e < NT; e++) begin
                span = (64'd1 << (e - s + 1)) - 64'd1;
                if (((64'(m) >> s) & span) == span && e - s + 1 > wl) begin
                    wl = e - s + 1;
                    ws = s;
                end
            end
        err = wl < 3 ? 1 : 0;
        tap = err ? 0 : ws + (wl - 1) / 2;
    endtask

    task automatic run_cal(input string name, input logic [31:0] m, input int g, input bit center_start);
        int ews, ewl, etap, eerr, n;
        mask = m;
        glitch = g;
        model(g >= 0 ? m & ~(32'd1 << g) : m, ews, ewl, etap, eerr);
        start = 1'b1;
        for (n = 1; n <= LAT + 200; n++) begin
            @(posedge clk);
            #2;
            start = (n == 300);
            if (n == 1) check({name, " busy"}, 64'(busy), 1);
            if (done) break;
        end
        check({name, " latency"}, n, LAT);
        check({name, " window_start"}, window_start, ews);
        check({name, " window_len"}, window_len, ewl);
        check({name, " delay_tap"}, delay_tap, etap);
        check({name, " error"}, 64'(error), eerr);
        check({name, " load"}, 64'(delay_load), 1);
        check({name, " busy_end"}, 64'(busy), 0);
        start = center_start;
        @(posedge clk);
        #2;
        start = 1'b0;
        check({name, " done_once"}, 64'(done), 0);
        check({name, " idle"}, 64'(busy), 0);
        check({name, " tap_hold"}, delay_tap, etap);
    endtask

    initial begin
        int n, dones, s, l;
        logic [31:0] m;
        repeat (3) @(posedge clk);
        #2;
        check("rst delay_tap", delay_tap, 0);
        check("rst load", 64'(delay_load), 0);
        check("rst busy", 64'(busy), 0);
        check("rst done", 64'(done), 0);
        check("rst error", 64'(error), 0);
        check("rst wstart", window_start, 0);
        check("rst wlen", window_len, 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        run_cal("w10_20", 32'h001F_FC00, -1, 1'b0);
        run_cal("two_win", 32'h03F0_001C, -1, 1'b1);
        run_cal("tie", 32'h0000_F078, -1, 1'b0);
        run_cal("none", 32'h0, -1, 1'b0);
        run_cal("len2", 32'h0000_0660, -1, 1'b0);

        mask = '1;
        glitch = -1;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (n = 0; n < 1200; n++) begin
            if (cur_tap == 7 && phase == 40) break;
            @(posedge clk);
            #2;
        end
        check("reach tap7", 64'(cur_tap == 7 && phase == 40), 1);
        rst = 1'b1;
        #1;
        check("abort delay_tap", delay_tap, 0);
        check("abort load", 64'(delay_load), 0);
        check("abort busy", 64'(busy), 0);
        check("abort done", 64'(done), 0);
        check("abort error", 64'(error), 0);
        check("abort wstart", window_start, 0);
        check("abort wlen", window_len, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #2;
            dones += int'(done);
        end
        check("abort no_done", dones, 0);
        check("abort idle", 64'(busy), 0);

        run_cal("all_pass", 32'hFFFF_FFFF, -1, 1'b0);
        run_cal("glitch12", 32'h0007_FF00, 12, 1'b0);
        for (int i = 0; i < 3; i++) begin
            s = $urandom_range(0, 25);
            l = $urandom_range(1, 12);
            m = ($urandom & $urandom) | 32'((64'd1 << l) - 64'd1) << s;
            run_cal($sformatf("rand%0d", i), m, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : -1, 1'(i));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
